// File: rtl/dbg_snap_pkg.sv
// Shared types and constants for the debug snapshot controller.
// Optional macro DBG_SNAP_TIMEOUT_EN (used in dbg_snap_ctrl) enables the per-read wait timeout.
package dbg_snap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } snap_state_e;

    // PS/2 make codes for the three control keys
    localparam logic [7:0] KEY_FREEZE = 8'h2B;
    localparam logic [7:0] KEY_PAGE   = 8'h4D;
    localparam logic [7:0] KEY_FORCE  = 8'h5A;

    localparam int DEF_NREG = 32;
    localparam int DEF_WIN  = 16;

    localparam logic [31:0] FILL_VALUE    = 32'hDEADBEEF;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'hFF;

    function automatic logic is_control_key(input logic [7:0] code);
        return (code == KEY_FREEZE) || (code == KEY_PAGE) || (code == KEY_FORCE);
    endfunction

endpackage

// File: rtl/dbg_key_decode.sv
// Turns a keyboard make-code strobe into one-cycle freeze/page/force pulses.
module dbg_key_decode
    import dbg_snap_pkg::*;
(
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       toggle_freeze,
    output logic       next_page,
    output logic       force_pulse
);

    always_comb begin
        toggle_freeze = 1'b0;
        next_page     = 1'b0;
        force_pulse   = 1'b0;
        if (key_valid && is_control_key(key_code)) begin
            case (key_code)
                KEY_FREEZE: toggle_freeze = 1'b1;
                KEY_PAGE:   next_page     = 1'b1;
                KEY_FORCE:  force_pulse   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dbg_snap_ctrl.sv
// Captures a coherent register window plus PC/instruction once per frame for the debug display.
// Define DBG_SNAP_TIMEOUT_EN to fill unanswered reads with a marker after a bounded wait.
module dbg_snap_ctrl
    import dbg_snap_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int WIN  = DEF_WIN,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       inst_in,
    output logic              rd_req,
    output logic [AW-1:0]     rd_addr,
    input  logic              rd_ack,
    input  logic [31:0]       rd_data,
    output logic [31:0]       pc_snap,
    output logic [31:0]       inst_snap,
    output logic [32*WIN-1:0] regs_flat,
    output logic [AW-1:0]     win_base,
    output logic              snap_valid,
    output logic              frozen,
    output logic              busy
);

    localparam int              IW        = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [AW-1:0]   PAGE_STEP = AW'(WIN % NREG);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(WIN - 1);

    snap_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [AW-1:0]          cur_base_q, cur_base_d;
    logic [AW-1:0]          page_pending_q, page_pending_d;
    logic                   force_pend_q, force_pend_d;
    logic                   frozen_q, frozen_d;
    logic [WIN-1:0][31:0]   shadow_q, shadow_d;
    logic [31:0]            pc_shadow_q, pc_shadow_d;
    logic [31:0]            inst_shadow_q, inst_shadow_d;

    logic                   rd_req_q, rd_req_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic [WIN-1:0][31:0]   regs_q, regs_d;
    logic [31:0]            pc_snap_q, pc_snap_d;
    logic [31:0]            inst_snap_q, inst_snap_d;
    logic [AW-1:0]          win_base_q, win_base_d;
    logic                   snap_valid_q, snap_valid_d;
    logic                   busy_q, busy_d;

    logic                   toggle_freeze, next_page, force_pulse;
    logic                   start_capture, last_read, advance, timeout_hit;
    logic [31:0]            slot_data;

    dbg_key_decode u_key_decode (
        .key_valid     (key_valid),
        .key_code      (key_code),
        .toggle_freeze (toggle_freeze),
        .next_page     (next_page),
        .force_pulse   (force_pulse)
    );

    // A pending force wins over freeze; a frame pulse arriving together with it still yields one capture
    assign start_capture = (state_q == ST_IDLE) && ((frame_start && !frozen_q) || force_pend_q);
    assign last_read     = (idx_q == LAST_IDX);
    assign advance       = (state_q == ST_READ) && (rd_ack || timeout_hit);
    assign slot_data     = rd_ack ? rd_data : FILL_VALUE;

`ifdef DBG_SNAP_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    assign timeout_hit = (wait_q == TIMEOUT_LIMIT);

    always_comb begin
        wait_d = 8'd0;
        if ((state_q == ST_READ) && !rd_ack && !timeout_hit) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_capture) state_d = ST_READ;
            ST_READ: if (advance && last_read) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d          = idx_q;
        cur_base_d     = cur_base_q;
        pc_shadow_d    = pc_shadow_q;
        inst_shadow_d  = inst_shadow_q;
        shadow_d       = shadow_q;
        page_pending_d = page_pending_q;
        force_pend_d   = force_pend_q;
        frozen_d       = frozen_q;

        if (start_capture) begin
            idx_d         = '0;
            cur_base_d    = page_pending_q;
            pc_shadow_d   = pc_in;
            inst_shadow_d = inst_in;
        end
        if (advance) begin
            shadow_d[idx_q] = slot_data;
            if (!last_read) begin
                idx_d = idx_q + IW'(1);
            end
        end

        if (toggle_freeze) begin
            frozen_d = !frozen_q;
        end
        if (next_page) begin
            page_pending_d = page_pending_q + PAGE_STEP;
        end
        // A fresh Enter arriving as IDLE is left is kept rather than lost
        if (start_capture) begin
            force_pend_d = 1'b0;
        end
        if (force_pulse) begin
            force_pend_d = 1'b1;
        end
    end

    always_comb begin
        rd_req_d     = (state_d == ST_READ);
        busy_d       = (state_d != ST_IDLE);
        rd_addr_d    = rd_addr_q;
        regs_d       = regs_q;
        pc_snap_d    = pc_snap_q;
        inst_snap_d  = inst_snap_q;
        win_base_d   = win_base_q;
        snap_valid_d = snap_valid_q;

        if (rd_req_d) begin
            rd_addr_d = cur_base_d + AW'(idx_d);
        end
        if (state_q == ST_DONE) begin
            regs_d       = shadow_q;
            pc_snap_d    = pc_shadow_q;
            inst_snap_d  = inst_shadow_q;
            win_base_d   = cur_base_q;
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q          <= '0;
            cur_base_q     <= '0;
            page_pending_q <= '0;
            force_pend_q   <= 1'b0;
            frozen_q       <= 1'b0;
            shadow_q       <= '0;
            pc_shadow_q    <= '0;
            inst_shadow_q  <= '0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            regs_q         <= '0;
            pc_snap_q      <= '0;
            inst_snap_q    <= '0;
            win_base_q     <= '0;
            snap_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            cur_base_q     <= cur_base_d;
            page_pending_q <= page_pending_d;
            force_pend_q   <= force_pend_d;
            frozen_q       <= frozen_d;
            shadow_q       <= shadow_d;
            pc_shadow_q    <= pc_shadow_d;
            inst_shadow_q  <= inst_shadow_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            regs_q         <= regs_d;
            pc_snap_q      <= pc_snap_d;
            inst_snap_q    <= inst_snap_d;
            win_base_q     <= win_base_d;
            snap_valid_q   <= snap_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign regs_flat  = regs_q;
    assign pc_snap    = pc_snap_q;
    assign inst_snap  = inst_snap_q;
    assign win_base   = win_base_q;
    assign snap_valid = snap_valid_q;
    assign frozen     = frozen_q;
    assign busy       = busy_q;

endmodule
